// File: rtl/msdap_pkg.sv
// Shared MSDAP definitions: accumulator word width and output-capture FSM states.
package msdap_pkg;

  localparam int unsigned MSDAP_WORD_W = 40;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_LOW
  } cap_state_t;

endpackage

// File: rtl/msdap_word_fifo.sv
// Synchronous FIFO for captured left/right word pairs; drops pushes when full with no pop.
module msdap_word_fifo #(
  parameter int unsigned WIDTH = 80,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic             overflow_q;
  logic             empty, full, do_pop, do_push;

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !do_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign rdata    = mem_q[rd_ptr_q[AddrW-1:0]];
  assign valid    = !empty;
  assign level    = wr_ptr_q - rd_ptr_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/msdap_output_capture.sv
// Reassembles MSDAP serial left/right results into parallel word pairs and queues them
// for a valid/ready consumer; flags short frames and queue overflow.
module msdap_output_capture
  import msdap_pkg::*;
#(
  parameter int unsigned WORD_W = MSDAP_WORD_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     SCLK,
  input  logic                     Reset_n,
  input  logic                     OutputL,
  input  logic                     OutputR,
  input  logic                     OutReady,
  output logic [WORD_W-1:0]        word_l,
  output logic [WORD_W-1:0]        word_r,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int unsigned CntW = $clog2(WORD_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WORD_W - 1);

  cap_state_t          state_q, state_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic                frame_err_q, frame_err_d;
  logic                push;
  logic [2*WORD_W-1:0] push_data, head;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_l_d      = sh_l_q;
    sh_r_d      = sh_r_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_data   = {sh_l_q[WORD_W-2:0], OutputL, sh_r_q[WORD_W-2:0], OutputR};
    unique case (state_q)
      IDLE: begin
        if (OutReady) begin
          sh_l_d    = {{(WORD_W-1){1'b0}}, OutputL};
          sh_r_d    = {{(WORD_W-1){1'b0}}, OutputR};
          bit_cnt_d = CntW'(1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!OutReady) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          sh_l_d      = '0;
          sh_r_d      = '0;
          state_d     = IDLE;
        end else if (bit_cnt_q == LastCnt) begin
          // Final bit goes straight into the FIFO, not through the shifters.
          push      = 1'b1;
          bit_cnt_d = '0;
          sh_l_d    = '0;
          sh_r_d    = '0;
          state_d   = WAIT_LOW;
        end else begin
          sh_l_d    = {sh_l_q[WORD_W-2:0], OutputL};
          sh_r_d    = {sh_r_q[WORD_W-2:0], OutputR};
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      WAIT_LOW: begin
        if (!OutReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      frame_err_q <= frame_err_d;
    end
  end

  msdap_word_fifo #(
    .WIDTH (2 * WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (SCLK),
    .rst_n    (Reset_n),
    .push     (push),
    .wdata    (push_data),
    .pop      (word_ready),
    .rdata    (head),
    .valid    (word_valid),
    .level    (level),
    .overflow (overflow)
  );

  assign word_l    = head[2*WORD_W-1:WORD_W];
  assign word_r    = head[WORD_W-1:0];
  assign frame_err = frame_err_q;

endmodule
